// File: rtl/add_sub_unit_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_unit_pkg
// Shared constants for the add/subtract datapath core.
//   DATA_SIZE_DEFAULT : default operand/result width in bits
//   ADD / SUB         : encoding of the add_sub control input
// ---------------------------------------------------------------------------
package add_sub_unit_pkg;

    localparam int   DATA_SIZE_DEFAULT = 32;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage : add_sub_unit_pkg

// File: rtl/add_sub_unit_if.sv
// ---------------------------------------------------------------------------
// add_sub_unit_if
// Operand/result bundle of the add/subtract unit.
//   master : drives data_a, data_b, add_sub, in_valid; observes the results
//   slave  : the arithmetic unit; consumes operands, drives sum_out, carry,
//            overflow, zero, negative, out_valid
// ---------------------------------------------------------------------------
interface add_sub_unit_if
    import add_sub_unit_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
);

    logic [DATA_SIZE-1:0] data_a;
    logic [DATA_SIZE-1:0] data_b;
    logic                 add_sub;
    logic                 in_valid;
    logic [DATA_SIZE-1:0] sum_out;
    logic                 carry;
    logic                 overflow;
    logic                 zero;
    logic                 negative;
    logic                 out_valid;

    modport master (
        output data_a, data_b, add_sub, in_valid,
        input  sum_out, carry, overflow, zero, negative, out_valid
    );

    modport slave (
        input  data_a, data_b, add_sub, in_valid,
        output sum_out, carry, overflow, zero, negative, out_valid
    );

endinterface : add_sub_unit_if

// File: rtl/add_sub_unit_full_adder_bit.sv
// ---------------------------------------------------------------------------
// full_adder_bit
// One-bit full adder, the building block of the ripple-carry chain.
//   a, b, cin : addend bits and incoming carry
//   s         : sum bit
//   cout      : outgoing carry (majority of a, b, cin)
// ---------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/add_sub_unit.sv
// ---------------------------------------------------------------------------
// add_sub_unit
// Two's-complement adder/subtractor with registered result and flags.
// Subtraction is A + ~B + 1: B is conditionally inverted and the add_sub bit
// is injected as the carry-in of bit 0.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears all outputs
//   bus   : add_sub_unit_if.slave (operands, control, result and flags)
// Latency is one cycle; one operation per cycle, no back-pressure.
// ---------------------------------------------------------------------------
module add_sub_unit
    import add_sub_unit_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    add_sub_unit_if.slave  bus
);

    // Combinational datapath
    logic                 b_invert_s;
    logic [DATA_SIZE-1:0] b_eff_s;
    logic [DATA_SIZE:0]   carry_chain_s;
    logic [DATA_SIZE-1:0] sum_s;
    logic                 overflow_s;

    // Result/flag registers
    logic [DATA_SIZE-1:0] sum_d,       sum_q;
    logic                 carry_d,     carry_q;
    logic                 overflow_d,  overflow_q;
    logic                 zero_d,      zero_q;
    logic                 negative_d,  negative_q;
    logic                 out_valid_d, out_valid_q;

    assign b_invert_s       = (bus.add_sub == SUB);
    assign b_eff_s          = bus.data_b ^ {DATA_SIZE{b_invert_s}};
    // The "+1" of the two's-complement negation enters as carry-in.
    assign carry_chain_s[0] = b_invert_s;

    for (genvar i = 0; i < DATA_SIZE; i++) begin : g_bit
        full_adder_bit u_fa (
            .a    (bus.data_a[i]),
            .b    (b_eff_s[i]),
            .cin  (carry_chain_s[i]),
            .s    (sum_s[i]),
            .cout (carry_chain_s[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow_s = carry_chain_s[DATA_SIZE] ^ carry_chain_s[DATA_SIZE-1];

    // Next-state: capture a new result on in_valid, otherwise hold the result.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d       = sum_s;
            carry_d     = carry_chain_s[DATA_SIZE];
            overflow_d  = overflow_s;
            zero_d      = (sum_s == {DATA_SIZE{1'b0}});
            negative_d  = sum_s[DATA_SIZE-1];
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Result register with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= {DATA_SIZE{1'b0}};
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum_out   = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.out_valid = out_valid_q;

endmodule : add_sub_unit

// File: tb/tb_add_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_add_sub_unit
// Directed bench for add_sub_unit (DATA_SIZE = 32). Each observation packs
// {sum_out, carry, overflow, zero, negative, out_valid} into 37 bits and is
// compared against a hand-computed expectation.
// ---------------------------------------------------------------------------
module tb_add_sub_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    add_sub_unit_if #(.DATA_SIZE(32)) bus ();

    add_sub_unit #(.DATA_SIZE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, limit 100000 time units");
        $fatal(1, "watchdog expired");
    end

    // Drive one operand set on the falling edge
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic v);
        @(negedge clk);
        bus.data_a   = a;
        bus.data_b   = b;
        bus.add_sub  = op;
        bus.in_valid = v;
    endtask

    // Wait for the capturing edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] pack_obs();
        return {bus.sum_out, bus.carry, bus.overflow, bus.zero, bus.negative, bus.out_valid};
    endfunction

    task automatic test_reset();
        logic [36:0] obs;
        reset = 1'b1;
        drive(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, want %h", obs, 37'h0);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [36:0] obs;
        drive(32'd1505, 32'd1900, 1'b0, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h0000_0D4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_basic: got %h, want %h", obs,
                     {32'h0000_0D4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_sub_borrow();
        logic [36:0] obs;
        drive(32'd1505, 32'd1900, 1'b1, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'hFFFF_FE75, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h, want %h", obs,
                     {32'hFFFF_FE75, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_sub_zero();
        logic [36:0] obs;
        drive(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_zero: got %h, want %h", obs,
                     {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_wrap();
        logic [36:0] obs;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL unsigned_wrap: got %h, want %h", obs,
                     {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_overflow();
        logic [36:0] obs;
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_add: got %h, want %h", obs,
                     {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        end
        drive(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sub: got %h, want %h", obs,
                     {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_hold();
        logic [36:0] obs;
        drive(32'd40, 32'd2, 1'b1, 1'b1);
        step();
        // Operands change while in_valid is low: result must not follow them.
        drive(32'd7, 32'd9, 1'b0, 1'b0);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'd38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_1: got %h, want %h", obs,
                     {32'd38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'd38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_2: got %h, want %h", obs,
                     {32'd38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_midstream();
        logic [36:0] obs;
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step();
        // Reset wins over a valid operand set on the same edge.
        @(negedge clk);
        reset        = 1'b1;
        bus.data_a   = 32'd3;
        bus.data_b   = 32'd4;
        bus.in_valid = 1'b1;
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %h, want %h", obs, 37'h0);
        end
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            obs = pack_obs();
            n_cmp++;
            if (obs !== 37'h0) begin
                n_fail++;
                $display("FAIL post_reset_idle%0d: got %h, want %h", k, obs, 37'h0);
            end
        end
        drive(32'd3, 32'd4, 1'b0, 1'b1);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_after_reset: got %h, want %h", obs,
                     {32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vop[8];
        logic [36:0] vexp[8];
        logic [36:0] obs;
        // a, b, op -> {sum, carry, ovf, zero, neg, valid}
        va[0] = 32'd10;        vb[0] = 32'd5;         vop[0] = 1'b0; vexp[0] = {32'd15,        5'b00001};
        va[1] = 32'd10;        vb[1] = 32'd5;         vop[1] = 1'b1; vexp[1] = {32'd5,         5'b10001};
        va[2] = 32'd5;         vb[2] = 32'd10;        vop[2] = 1'b1; vexp[2] = {32'hFFFF_FFFB, 5'b00011};
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vop[3] = 1'b0; vexp[3] = {32'h0,         5'b11101};
        va[4] = 32'd100;       vb[4] = 32'd1;         vop[4] = 1'b1; vexp[4] = {32'd99,        5'b10001};
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vop[5] = 1'b0; vexp[5] = {32'hFFFF_FFFE, 5'b10011};
        va[6] = 32'h0;         vb[6] = 32'h0;         vop[6] = 1'b1; vexp[6] = {32'h0,         5'b10101};
        va[7] = 32'h4000_0000; vb[7] = 32'h4000_0000; vop[7] = 1'b0; vexp[7] = {32'h8000_0000, 5'b01011};
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], vop[i], 1'b1);
            step();
            obs = pack_obs();
            n_cmp++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h, want %h", i, obs, vexp[i]);
            end
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        step();
        obs = pack_obs();
        n_cmp++;
        if (obs !== {32'h8000_0000, 5'b01010}) begin
            n_fail++;
            $display("FAIL b2b_drain: got %h, want %h", obs, {32'h8000_0000, 5'b01010});
        end
    endtask

    // Test sequence
    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.data_a   = 32'h0;
        bus.data_b   = 32'h0;
        bus.add_sub  = 1'b0;
        bus.in_valid = 1'b0;
        test_reset();
        test_add();
        test_sub_borrow();
        test_sub_zero();
        test_wrap();
        test_overflow();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_add_sub_unit
